// File: rtl/rle_qspi_fetch.sv
`default_nettype none
// ============================================================================
// Module   : rle_qspi_fetch
// Purpose  : Drives the external QSPI flash holding the RLE image. On every
//            frame_start it issues a Quad Output Fast Read at START_ADDR, then
//            streams 16-bit run words into a 2-entry FIFO that feeds the
//            RLE/VGA decoder over a valid/ready handshake. SCK is held low
//            whenever the FIFO could not accept another word.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            frame_start       - one-cycle pulse, (re)starts the read
//            spi_cs_n/spi_clk  - flash chip select (active low) and SCK
//            spi_mosi/spi_d_oe - IO0 serial out and its output enable
//            spi_miso[3:0]     - quad data in (bit3 = IO3)
//            data_out/data_valid/data_ready - decoder word stream
// Revision : 1.0 - initial release
// ============================================================================
module rle_qspi_fetch #(
    parameter logic [23:0] START_ADDR     = 24'h000000,
    parameter logic [7:0]  READ_CMD       = 8'h6B,
    parameter int          DUMMY_CYCLES   = 8,   // must be >= 1
    parameter int          CS_HIGH_CYCLES = 2    // must be >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    output logic        spi_cs_n,
    output logic        spi_clk,
    output logic        spi_mosi,
    output logic        spi_d_oe,
    input  logic [3:0]  spi_miso,
    output logic [15:0] data_out,
    output logic        data_valid,
    input  logic        data_ready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CS_WAIT = 3'd1,
        S_CMD     = 3'd2,
        S_ADDR    = 3'd3,
        S_DUMMY   = 3'd4,
        S_DATA    = 3'd5,
        S_STALL   = 3'd6
    } state_t;

    localparam logic [15:0] c_CS_LAST    = 16'(CS_HIGH_CYCLES - 1);
    localparam logic [15:0] c_DUMMY_LAST = 16'(DUMMY_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;       // bit / nibble / wait counter within a state
    logic        r_phase, w_phase_nxt;   // current SCK level (0 = low half of a bit)
    logic [31:0] r_tx, w_tx_nxt;         // {READ_CMD, START_ADDR}, MSB on IO0
    logic [11:0] r_sh, w_sh_nxt;         // first three nibbles of the word in flight

    logic [15:0] r_mem [0:1];
    logic        r_head;
    logic [1:0]  r_count;

    logic        w_push, w_pop, w_flush;
    logic [15:0] w_word;
    logic [1:0]  w_occ_after_pop;

    assign w_pop           = (r_count != 2'd0) && data_ready;
    assign w_occ_after_pop = r_count - {1'b0, w_pop};
    assign w_word          = {r_sh, spi_miso};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_tx    <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
            r_tx    <= w_tx_nxt;
            r_sh    <= w_sh_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Every serial bit/nibble is a low cycle followed by
    // a high cycle; counters advance and data shifts at the edge that ends
    // the high cycle, so IO0 only changes while SCK is low.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_tx_nxt    = r_tx;
        w_sh_nxt    = r_sh;
        w_push      = 1'b0;
        w_flush     = 1'b0;

        if (frame_start) begin
            w_state_nxt = S_CS_WAIT;
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b0;
            w_flush     = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_CS_WAIT: begin
                    if (r_cnt == c_CS_LAST) begin
                        w_state_nxt = S_CMD;
                        w_cnt_nxt   = '0;
                        w_tx_nxt    = {READ_CMD, START_ADDR};
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_CMD, S_ADDR, S_DUMMY: begin
                    w_phase_nxt = ~r_phase;
                    if (r_phase) begin
                        w_tx_nxt  = {r_tx[30:0], 1'b0};
                        w_cnt_nxt = r_cnt + 16'd1;
                        if (r_state == S_CMD && r_cnt == 16'd7) begin
                            w_state_nxt = S_ADDR;
                            w_cnt_nxt   = '0;
                        end else if (r_state == S_ADDR && r_cnt == 16'd23) begin
                            w_state_nxt = S_DUMMY;
                            w_cnt_nxt   = '0;
                        end else if (r_state == S_DUMMY && r_cnt == c_DUMMY_LAST) begin
                            w_state_nxt = S_DATA;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                S_DATA: begin
                    if (!r_phase) begin
                        // A word may only start if the FIFO will have room for
                        // it; pushes happen 8 cycles later and pops only help.
                        if (r_cnt == 16'd0 && w_occ_after_pop == 2'd2) begin
                            w_state_nxt = S_STALL;
                        end else begin
                            w_phase_nxt = 1'b1;
                        end
                    end else begin
                        w_phase_nxt = 1'b0;
                        w_sh_nxt    = {r_sh[7:0], spi_miso};
                        if (r_cnt == 16'd3) begin
                            w_push    = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 16'd1;
                        end
                    end
                end
                S_STALL: begin
                    if (w_occ_after_pop != 2'd2) begin
                        w_state_nxt = S_DATA;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO. The write slot is head+count, so a push with a
    // simultaneous pop at occupancy 1 lands behind the departing head.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_count  <= 2'd0;
        end else if (w_flush) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_head ^ r_count[0]] <= w_word;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign spi_cs_n   = (r_state == S_IDLE) || (r_state == S_CS_WAIT);
    assign spi_clk    = r_phase;
    assign spi_d_oe   = (r_state == S_CMD) || (r_state == S_ADDR);
    assign spi_mosi   = spi_d_oe && r_tx[31];
    assign data_valid = (r_count != 2'd0);
    assign data_out   = r_mem[r_head];

endmodule
`default_nettype wire

// File: tb/tb_rle_qspi_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_rle_qspi_fetch
// Purpose  : Self-checking bench for rle_qspi_fetch. A flash model serves
//            words from an array by counting SCK pulses; each frame_start
//            queues the expected word stream, which a monitor pops and
//            compares on every accepted handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rle_qspi_fetch;

    localparam int c_CS  = 2;
    localparam int c_DUM = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        spi_cs_n, spi_clk, spi_mosi, spi_d_oe;
    logic [3:0]  spi_miso;
    logic [15:0] data_out;
    logic        data_valid;
    logic        data_ready;

    always #5 clk = ~clk;

    rle_qspi_fetch #(
        .START_ADDR     (24'h000000),
        .READ_CMD       (8'h6B),
        .DUMMY_CYCLES   (c_DUM),
        .CS_HIGH_CYCLES (c_CS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .spi_cs_n   (spi_cs_n),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_d_oe   (spi_d_oe),
        .spi_miso   (spi_miso),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Flash model: counts SCK high cycles since chip select fell. The first
    // 32 carry the command/address (captured from IO0), then DUMMY, then
    // nibble k of the data stream is presented for the k-th data pulse.
    // ------------------------------------------------------------------
    logic [15:0] flash_mem [256];
    int          fl_edges;
    logic [31:0] fl_mosi;
    int          fl_oe;
    int          bnd_viol = 0;
    int          mon_pops;

    always @(posedge clk) begin
        if (rst || spi_cs_n) begin
            fl_edges <= 0;
            fl_mosi  <= '0;
        end else if (spi_clk) begin
            fl_edges <= fl_edges + 1;
            if (fl_edges < 32) fl_mosi <= {fl_mosi[30:0], spi_mosi};
            // A word's first nibble clock must never run with a full buffer.
            if (!frame_start && fl_edges >= 32 + c_DUM && ((fl_edges - 32 - c_DUM) % 4) == 0 &&
                ((fl_edges - 32 - c_DUM) / 4) - mon_pops > 1)
                bnd_viol <= bnd_viol + 1;
        end
        if (rst || frame_start) fl_oe <= 0;
        else if (spi_d_oe)      fl_oe <= fl_oe + 1;
    end

    always_comb begin
        int idx;
        idx      = fl_edges - 32 - c_DUM;
        spi_miso = 4'h0;
        if (idx >= 0 && (idx / 4) < 256)
            spi_miso = flash_mem[idx / 4][(3 - (idx % 4)) * 4 +: 4];
    end

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    logic [15:0] sb [$];

    always @(negedge clk) begin
        logic [15:0] exp_w;
        if (rst || frame_start) begin
            mon_pops = 0;
        end else if (data_valid && data_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_w = sb.pop_front();
                check("data_word", {16'h0, data_out}, {16'h0, exp_w});
            end
            mon_pops++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic start_frame();
        @(posedge clk); #1;
        frame_start = 1'b1;
        sb.delete();
        for (int i = 0; i < 256; i++) sb.push_back(flash_mem[i]);
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Called right after start_frame: cycle t+1 is the next negedge.
    task automatic frame_latency(output int first, output int cs_bad);
        first  = -1;
        cs_bad = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n <= c_CS && (spi_cs_n !== 1'b1 || spi_clk !== 1'b0)) cs_bad++;
            if (n == c_CS + 1 && spi_cs_n !== 1'b0) cs_bad++;
            if (data_valid) begin
                first = n;
                break;
            end
        end
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int c = 0;
        while (mon_pops < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, {31'h0, mon_pops >= n}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol, first, cs_bad, e0, v0;
        rst = 1'b1; frame_start = 1'b0; data_ready = 1'b0;
        for (int i = 0; i < 256; i++) flash_mem[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and quiet idle
        @(negedge clk);
        check("rst_outputs", {26'h0, spi_cs_n, spi_clk, spi_mosi, spi_d_oe, data_valid, 1'b0},
              {26'h0, 6'b100000});
        check("rst_data_out", {16'h0, data_out}, 32'h0);
        viol = 0;
        repeat (200) begin
            @(negedge clk);
            if (spi_cs_n !== 1'b1 || spi_clk !== 1'b0 || data_valid !== 1'b0) viol++;
        end
        check("idle_quiet", viol, 0);

        // Basic read: command, latency, word order
        flash_mem[0] = 16'h1234; flash_mem[1] = 16'hABCD; flash_mem[2] = 16'h0F0F;
        data_ready = 1'b1;
        start_frame();
        frame_latency(first, cs_bad);
        check("first_valid_latency", first, c_CS + 89);
        check("cs_wait_shape", cs_bad, 0);
        check("mosi_cmd_addr", fl_mosi, 32'h6B000000);
        check("d_oe_cycles", fl_oe, 64);
        wait_pops(3, 200, "basic_words_timeout");

        // Stall: nothing accepted, two words buffered, SCK parked low
        data_ready = 1'b0;
        start_frame();
        repeat (160) @(negedge clk);
        check("stall_valid", {31'h0, data_valid}, 32'd1);
        check("stall_cs_low", {31'h0, spi_cs_n}, 32'd0);
        check("stall_head", {16'h0, data_out}, 32'h1234);
        e0 = fl_edges;
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (data_out !== 16'h1234 || spi_clk !== 1'b0 || spi_cs_n !== 1'b0) viol++;
        end
        check("stall_hold", viol, 0);
        check("stall_no_sck", fl_edges, e0);
        @(posedge clk); #1 data_ready = 1'b1;
        wait_pops(3, 200, "stall_release_timeout");

        // Counting pattern, decoder ready one cycle in three
        data_ready = 1'b0;
        for (int i = 0; i < 256; i++) flash_mem[i] = 16'(i);
        v0 = bnd_viol;
        start_frame();
        for (int k = 0; k < 5000 && mon_pops < 100; k++) begin
            @(posedge clk); #1 data_ready = (k % 3 == 0);
        end
        check("count_100_words", {31'h0, mon_pops >= 100}, 32'd1);
        check("count_boundary", bnd_viol - v0, 0);

        // Restart mid-data after five words
        data_ready = 1'b1;
        for (int i = 0; i < 256; i++) flash_mem[i] = 16'($urandom);
        start_frame();
        wait_pops(5, 400, "restart_prefill_timeout");
        start_frame();
        check("restart_valid_drop", {31'h0, data_valid}, 32'd0);
        frame_latency(first, cs_bad);
        check("restart_latency", first, c_CS + 89 - 1 + 1);
        check("restart_cs_wait", cs_bad, 0);
        check("restart_cmd", fl_mosi, 32'h6B000000);
        wait_pops(4, 200, "restart_words_timeout");

        // Random words, sparse random ready so the buffer fills often
        data_ready = 1'b0;
        for (int i = 0; i < 256; i++) flash_mem[i] = 16'($urandom);
        v0 = bnd_viol;
        start_frame();
        for (int k = 0; k < 8000 && mon_pops < 40; k++) begin
            @(posedge clk); #1 data_ready = ($urandom_range(0, 9) < 1);
        end
        check("random_40_words", {31'h0, mon_pops >= 40}, 32'd1);
        check("random_boundary", bnd_viol - v0, 0);

        // Reset in the middle of the address phase
        data_ready = 1'b1;
        start_frame();
        repeat (c_CS + 30) @(negedge clk);
        check("in_addr_phase", {31'h0, spi_d_oe}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midaddr_rst_outputs",
              {26'h0, spi_cs_n, spi_clk, spi_mosi, spi_d_oe, data_valid, 1'b0},
              {26'h0, 6'b100000});
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (spi_clk !== 1'b0 || spi_cs_n !== 1'b1 || data_valid !== 1'b0) viol++;
        end
        check("post_rst_quiet", viol, 0);
        start_frame();
        frame_latency(first, cs_bad);
        check("post_rst_latency", first, c_CS + 89);
        wait_pops(2, 200, "post_rst_words_timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
